spi_reg_slave: RTL and testbench

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

---
 rtl/spi_reg_slave.sv | 234 +++++++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// -----------------------------------------------------------------------------
// spi_reg_slave
// SPI (mode 0, MSB first) slave in front of an NREG x 8-bit register file,
// with a host-side write/read port. Everything runs on sysclk; the SPI pins
// are oversampled through synchronizer chains.
//
// Transaction: CS_n falls, a header byte (bit7 = read, bit6 = burst,
// bits5:0 = address) is shifted in while status_in is shifted out. Data
// bytes follow. Writes land in the register file and are echoed on
// spi_wr/spi_addr/spi_wdata. Reads stream the register contents. Burst
// auto-increments the address with 6-bit wrap. Non-burst ignores any byte
// after the first data byte.
//
// Ports
//   sysclk, rstn             clock, async active-low reset
//   SCLK, MOSI, CS_n, MISO   SPI pins
//   status_in[7:0]           byte returned while the header is received
//   hw_we, hw_addr, hw_wdata host write port
//   hw_rdata[7:0]            registered read of reg[hw_addr]
//   spi_wr, spi_addr, spi_wdata  one-cycle notification of an SPI write
//   busy                     synchronized chip select is active
// -----------------------------------------------------------------------------
module spi_reg_slave #(
    parameter int NREG        = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic       sysclk,
    input  logic       rstn,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       CS_n,
    output logic       MISO,
    input  logic [7:0] status_in,
    input  logic       hw_we,
    input  logic [5:0] hw_addr,
    input  logic [7:0] hw_wdata,
    output logic [7:0] hw_rdata,
    output logic       spi_wr,
    output logic [5:0] spi_addr,
    output logic [7:0] spi_wdata,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_IGNORE = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_rise_s, sclk_fall_s, cs_fall_s;

    state_t     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       rw_q, rw_d, burst_q, burst_d;
    logic [5:0] addr_q, addr_d;
    logic       miso_q, miso_d;
    logic       spi_wr_q, spi_wr_d;
    logic [5:0] spi_addr_q, spi_addr_d;
    logic [7:0] spi_wdata_q, spi_wdata_d;
    logic       busy_q;
    logic [7:0] hw_rdata_q;
    logic [7:0] regs_q [NREG];

    logic       spi_we_s;
    logic [7:0] byte_s;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_s & sclk_prev_q;
    assign cs_fall_s   = ~cs_s & cs_prev_q;

    // Input synchronizers plus one extra sample for edge detection.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_n};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    // Transaction FSM: next state, shift registers and write request.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        rw_d     = rw_q;
        burst_d  = burst_q;
        addr_d   = addr_q;
        spi_we_s = 1'b0;
        byte_s   = {rx_q, mosi_s};
        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d  = ST_HEADER;
                    bitcnt_d = 3'd0;
                    rx_d     = 7'd0;
                    tx_d     = status_in;
                end else begin
                    tx_d = 8'h00;
                end
            end
            ST_HEADER, ST_DATA: begin
                if (cs_s) begin
                    // Chip select released: drop any partial byte.
                    state_d  = ST_IDLE;
                    bitcnt_d = 3'd0;
                    rx_d     = 7'd0;
                    tx_d     = 8'h00;
                end else if (sclk_rise_s) begin
                    rx_d     = byte_s[6:0];
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        if (state_q == ST_HEADER) begin
                            rw_d    = byte_s[7];
                            burst_d = byte_s[6];
                            addr_d  = byte_s[5:0];
                            state_d = ST_DATA;
                        end else begin
                            spi_we_s = ~rw_q;
                            if (burst_q) begin
                                addr_d = addr_q + 6'd1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end else begin
                        state_d = state_q;
                    end
                end else if (sclk_fall_s) begin
                    // Byte boundary in DATA: sample the register file now so
                    // later host writes cannot disturb the byte in flight.
                    if ((bitcnt_q == 3'd0) && (state_q == ST_DATA)) begin
                        tx_d = rw_q ? regs_q[addr_q] : 8'h00;
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end else begin
                    tx_d = tx_q;
                end
            end
            ST_IGNORE: begin
                if (cs_s) begin
                    state_d  = ST_IDLE;
                    bitcnt_d = 3'd0;
                    rx_d     = 7'd0;
                    tx_d     = 8'h00;
                end else begin
                    tx_d = 8'h00;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        miso_d      = ((state_d == ST_HEADER) || (state_d == ST_DATA)) ? tx_d[7] : 1'b0;
        spi_wr_d    = spi_we_s;
        spi_addr_d  = spi_we_s ? addr_q : spi_addr_q;
        spi_wdata_d = spi_we_s ? byte_s : spi_wdata_q;
    end

    // FSM and output registers.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'h00;
            rw_q        <= 1'b0;
            burst_q     <= 1'b0;
            addr_q      <= 6'd0;
            miso_q      <= 1'b0;
            spi_wr_q    <= 1'b0;
            spi_addr_q  <= 6'd0;
            spi_wdata_q <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            burst_q     <= burst_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            spi_wr_q    <= spi_wr_d;
            spi_addr_q  <= spi_addr_d;
            spi_wdata_q <= spi_wdata_d;
            busy_q      <= ~cs_s;
        end
    end

    // Register file; the SPI write is applied last so it wins a same-address collision.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 8'h00;
            end
            hw_rdata_q <= 8'h00;
        end else begin
            if (hw_we) begin
                regs_q[hw_addr] <= hw_wdata;
            end
            if (spi_we_s) begin
                regs_q[addr_q] <= byte_s;
            end
            hw_rdata_q <= regs_q[hw_addr];
        end
    end

    assign MISO      = miso_q;
    assign spi_wr    = spi_wr_q;
    assign spi_addr  = spi_addr_q;
    assign spi_wdata = spi_wdata_q;
    assign busy      = busy_q;
    assign hw_rdata  = hw_rdata_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: stimulus pushes expected MISO bytes and
// SPI write notifications into queues; monitors pop and compare.
module tb_spi_reg_slave;
    localparam int H = 8;   // SCLK half period in sysclk cycles

    logic       sysclk = 1'b0;
    logic       rstn;
    logic       SCLK = 1'b0, MOSI = 1'b0, CS_n = 1'b1;
    logic       MISO;
    logic [7:0] status_in = 8'h00;
    logic       hw_we = 1'b0;
    logic [5:0] hw_addr = 6'd0;
    logic [7:0] hw_wdata = 8'h00;
    logic [7:0] hw_rdata;
    logic       spi_wr;
    logic [5:0] spi_addr;
    logic [7:0] spi_wdata;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         chk;
        logic [7:0] val;
    } miso_exp_t;

    miso_exp_t   exp_miso_q[$];
    logic [13:0] exp_wr_q[$];
    logic [7:0]  mdl [64];
    logic [7:0]  data_buf [8];
    logic [7:0]  got_miso;
    event        miso_ev;

    always #5 sysclk = ~sysclk;

    spi_reg_slave #(.NREG(64), .SYNC_STAGES(2)) dut (
        .sysclk(sysclk), .rstn(rstn), .SCLK(SCLK), .MOSI(MOSI), .CS_n(CS_n),
        .MISO(MISO), .status_in(status_in), .hw_we(hw_we), .hw_addr(hw_addr),
        .hw_wdata(hw_wdata), .hw_rdata(hw_rdata), .spi_wr(spi_wr),
        .spi_addr(spi_addr), .spi_wdata(spi_wdata), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_miso(input bit c, input logic [7:0] v);
        miso_exp_t e;
        e.chk = c;
        e.val = v;
        exp_miso_q.push_back(e);
    endfunction

    // Monitor: every SPI write notification must match the next expected write.
    initial begin : wr_mon
        logic [13:0] e;
        forever begin
            @(negedge sysclk);
            if (spi_wr === 1'b1) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL spi_wr_unexpected: got addr %0d data %02h expected none", spi_addr, spi_wdata);
                end else begin
                    e = exp_wr_q.pop_front();
                    if ({spi_addr, spi_wdata} !== e) begin
                        errors++;
                        $display("FAIL spi_wr_payload: got %0d/%02h expected %0d/%02h",
                                 spi_addr, spi_wdata, e[13:8], e[7:0]);
                    end
                end
            end
        end
    end

    // Monitor: every byte the master receives is checked against the scoreboard.
    initial begin : miso_mon
        miso_exp_t e;
        forever begin
            @(miso_ev);
            if (exp_miso_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL miso_unexpected: got %02h expected no byte", got_miso);
            end else begin
                e = exp_miso_q.pop_front();
                if (e.chk) check("miso_byte", {24'd0, got_miso}, {24'd0, e.val});
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    task automatic sclk_wait(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic wait_spi_wr_release();
        int n = 0;
        while (spi_wr !== 1'b1 && n < 40) begin
            @(posedge sysclk);
            #1;
            n++;
        end
        hw_we = 1'b0;
        check("collide_spi_wr_seen", {31'd0, spi_wr}, 32'd1);
    endtask

    task automatic spi_byte(input logic [7:0] b, input int nbits, input bit collide, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            MOSI = b[i];
            sclk_wait(H);
            r[i] = MISO;
            if (collide && i == 0) begin
                hw_we = 1'b1; hw_addr = 6'd9; hw_wdata = 8'hAA;
            end
            SCLK = 1'b1;
            if (collide && i == 0) wait_spi_wr_release();
            sclk_wait(H);
            SCLK = 1'b0;
        end
    endtask

    task automatic reset_check();
        @(negedge sysclk);
        check("rst_miso", {31'd0, MISO}, 32'd0);
        check("rst_spi_wr", {31'd0, spi_wr}, 32'd0);
        check("rst_spi_addr", {26'd0, spi_addr}, 32'd0);
        check("rst_spi_wdata", {24'd0, spi_wdata}, 32'd0);
        check("rst_hw_rdata", {24'd0, hw_rdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
    endtask

    // Full SPI transaction: expectations come from the header rules alone.
    task automatic spi_xfer(input logic [7:0] hdr, input int nbytes, input int part_bits,
                            input bit rst_abort, input bit collide, input logic [7:0] status);
        logic [5:0] a;
        logic [7:0] r;
        bit rw, burst;
        rw = hdr[7]; burst = hdr[6]; a = hdr[5:0];
        status_in = status;
        push_miso(1'b1, status);
        for (int k = 0; k < nbytes; k++) begin
            if (k == 0 || burst) begin
                if (rw) begin
                    push_miso(1'b1, mdl[a]);
                end else begin
                    push_miso(1'b0, 8'h00);
                    exp_wr_q.push_back({a, data_buf[k]});
                    mdl[a] = data_buf[k];
                end
                if (burst) a = a + 6'd1;
            end else begin
                push_miso(1'b1, 8'h00);
            end
        end
        CS_n = 1'b0;
        sclk_wait(4);
        check("busy_active", {31'd0, busy}, 32'd1);
        spi_byte(hdr, 8, 1'b0, r);
        got_miso = r; ->miso_ev;
        for (int k = 0; k < nbytes; k++) begin
            spi_byte(data_buf[k], 8, collide && (k == 0), r);
            got_miso = r; ->miso_ev;
        end
        if (part_bits > 0) spi_byte(data_buf[nbytes], part_bits, 1'b0, r);
        if (rst_abort) begin
            rstn = 1'b0; CS_n = 1'b1; MOSI = 1'b0;
            repeat (3) @(posedge sysclk);
            reset_check();
            @(posedge sysclk); #1;
            rstn = 1'b1;
            sclk_wait(4);
        end else begin
            sclk_wait(H);
            CS_n = 1'b1;
            sclk_wait(6);
            @(negedge sysclk);
            check("end_busy", {31'd0, busy}, 32'd0);
            check("end_miso", {31'd0, MISO}, 32'd0);
            @(posedge sysclk); #1;
        end
    endtask

    task automatic hw_write(input logic [5:0] a, input logic [7:0] d);
        hw_we = 1'b1; hw_addr = a; hw_wdata = d;
        @(posedge sysclk); #1;
        hw_we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic hw_read(input logic [5:0] a);
        hw_addr = a;
        @(posedge sysclk);
        @(negedge sysclk);
        check("hw_rdata", {24'd0, hw_rdata}, {24'd0, mdl[a]});
        @(posedge sysclk); #1;
    endtask

    initial begin : stim
        int nb, pb, nw;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(posedge sysclk);
        reset_check();
        @(posedge sysclk); #1;
        rstn = 1'b1;
        sclk_wait(4);

        // Single write with status readback
        data_buf[0] = 8'h3C;
        spi_xfer(8'h05, 1, 0, 1'b0, 1'b0, 8'hA5);
        hw_read(6'd5);

        // Burst read wrapping 62 -> 63 -> 0
        hw_write(6'd62, 8'h11); hw_write(6'd63, 8'h22); hw_write(6'd0, 8'h33);
        spi_xfer(8'hFE, 3, 0, 1'b0, 1'b0, 8'h5A);

        // Non-burst overrun: only first data byte written, later byte reads 0
        data_buf[0] = 8'h77; data_buf[1] = 8'h88;
        spi_xfer(8'h02, 2, 0, 1'b0, 1'b0, 8'hC3);
        hw_read(6'd2);

        // Abort after 5 data bits
        hw_write(6'd3, 8'hC4);
        data_buf[0] = 8'hFF;
        spi_xfer(8'h43, 0, 5, 1'b0, 1'b0, 8'h81);
        hw_read(6'd3);

        // Collision: SPI wins at the same address
        data_buf[0] = 8'h55;
        spi_xfer(8'h09, 1, 0, 1'b0, 1'b1, 8'h00);
        hw_read(6'd9);

        // Reset in the middle of a burst write, then normal traffic
        data_buf[0] = 8'h12; data_buf[1] = 8'h34;
        spi_xfer(8'h4A, 1, 3, 1'b1, 1'b0, 8'h00);
        hw_read(6'd10);
        hw_read(6'd5);
        data_buf[0] = 8'h9C;
        spi_xfer(8'h0A, 1, 0, 1'b0, 1'b0, 8'h3E);
        spi_xfer(8'h8A, 1, 0, 1'b0, 1'b0, 8'h7F);
        hw_read(6'd10);

        // Randomized traffic
        for (int t = 0; t < 24; t++) begin
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) hw_write(6'($urandom), 8'($urandom));
            nb = $urandom_range(1, 4);
            for (int k = 0; k < 8; k++) data_buf[k] = 8'($urandom);
            pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            spi_xfer(8'($urandom), nb, pb, 1'b0, 1'b0, 8'($urandom));
            hw_read(6'($urandom));
        end

        sclk_wait(10);
        check("wr_queue_drained", exp_wr_q.size(), 32'd0);
        check("miso_queue_drained", exp_miso_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
